ysyx_220066_memrd: RTL and testbench

- Load unit for the MEM stage; the read-side counterpart of the store path.
- Accepts one load request at a time from EX (valid/ready), issues an 8-byte-aligned read on the data-memory read port, and waits for the response.
- Selects the byte lane(s) by addr[2:0] and sign- or zero-extends per MemOp.
- Returns the result to WB with a valid/ready handshake and an error code: misaligned, timeout or illegal op.

---
 rtl/ysyx_220066_mem_pkg.sv | 38 +++
 rtl/ysyx_220066_load_ext.sv | 34 +++
 rtl/ysyx_220066_memrd.sv | 128 ++++++++++++
 tb/tb_ysyx_220066_memrd.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_mem_pkg.sv
// Shared memory-access definitions: MemOp encodings (common with the store unit),
// load error codes and the load-unit state enum.
package ysyx_220066_mem_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LD  = 3'b011;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;
  localparam logic [2:0] MEMOP_LWU = 3'b110;
  localparam logic [2:0] MEMOP_ILL = 3'b111;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // memop[1:0] is log2 of the access size for every legal load.
  function automatic logic is_misaligned(input logic [2:0] memop, input logic [2:0] addr);
    logic mis;
    case (memop[1:0])
      2'b01:   mis = addr[0];
      2'b10:   mis = |addr[1:0];
      2'b11:   mis = |addr;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_220066_load_ext.sv
// Combinational byte-lane select and sign/zero extension of an aligned
// doubleword for a load of the given MemOp at byte offset addr_i.
module ysyx_220066_load_ext
  import ysyx_220066_mem_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [2:0]  addr_i,
  input  logic [2:0]  memop_i,
  output logic [63:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  assign byte_v = data_i[{addr_i, 3'b000} +: 8];
  assign half_v = data_i[{addr_i[2:1], 4'b0000} +: 16];
  assign word_v = data_i[{addr_i[2], 5'b00000} +: 32];

  always_comb begin
    result_o = 64'd0;
    case (memop_i)
      MEMOP_LB:  result_o = {{56{byte_v[7]}}, byte_v};
      MEMOP_LH:  result_o = {{48{half_v[15]}}, half_v};
      MEMOP_LW:  result_o = {{32{word_v[31]}}, word_v};
      MEMOP_LD:  result_o = data_i;
      MEMOP_LBU: result_o = {56'd0, byte_v};
      MEMOP_LHU: result_o = {48'd0, half_v};
      MEMOP_LWU: result_o = {32'd0, word_v};
      default:   result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_memrd.sv
// MEM-stage load unit: one load at a time, aligned doubleword read, lane select and
// extension, result to WB with an error code (misaligned / timeout / illegal op).
module ysyx_220066_memrd
  import ysyx_220066_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_addr,
  input  logic [2:0]  in_memop,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic [1:0]  out_err
);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  memop_q, memop_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] data_q, data_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] ext_result;

  ysyx_220066_load_ext u_load_ext (
    .data_i   (mem_resp_data),
    .addr_i   (addr_q[2:0]),
    .memop_i  (memop_q),
    .result_o (ext_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= 64'd0;
      memop_q <= 3'd0;
      rd_q    <= 5'd0;
      data_q  <= 64'd0;
      err_q   <= ERR_OK;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      memop_q <= memop_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    memop_d = memop_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = in_addr;
          memop_d = in_memop;
          rd_d    = in_rd;
          data_d  = 64'd0;
          // Faulting loads skip memory entirely and report straight away.
          if (in_memop == MEMOP_ILL) begin
            err_d   = ERR_ILLEGAL;
            state_d = S_DONE;
          end else if (is_misaligned(in_memop, in_addr[2:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = S_DONE;
          end else begin
            err_d   = ERR_OK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the final timeout cycle still counts as success.
        if (mem_resp_valid) begin
          data_d  = ext_result;
          err_d   = ERR_OK;
          state_d = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          data_d  = 64'd0;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {addr_q[63:3], 3'b000};
  assign out_valid     = (state_q == S_DONE);
  assign out_data      = data_q;
  assign out_rd        = rd_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_ysyx_220066_memrd.sv
// Scoreboard bench for the load unit: a driver issues loads and plays memory,
// pushing reference results; a monitor pops and compares on each WB handshake.
module tb_ysyx_220066_memrd;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_addr = 64'd0;
  logic [2:0]  in_memop = 3'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  out_err;

  int n_cmp = 0;
  int n_bad = 0;
  int bp_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic [70:0] exp_q[$];
  logic [70:0] exp_e;
  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [70:0] prev_out = '0;

  ysyx_220066_memrd #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_memop       (in_memop),
    .in_rd          (in_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_rd         (out_rd),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [70:0] act, input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference: size = 2^op[1:0] bytes, value taken from byte offset addr%8.
  function automatic logic [65:0] ref_load(input logic [63:0] a, input logic [2:0] op,
                                           input logic [63:0] d);
    int nb;
    logic [63:0] v, m;
    if (op == 3'b111) return {2'b11, 64'd0};
    nb = 1 << op[1:0];
    if ((a & 64'(nb - 1)) != 64'd0) return {2'b01, 64'd0};
    v = d >> (8 * a[2:0]);
    m = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v = v & m;
    if (!op[2] && nb < 8 && v[8*nb-1]) v = v | ~m;
    return {2'b00, v};
  endfunction

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: result stability under backpressure and scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_vld && !prev_rdy) begin
        check1("hold_valid", out_valid, 1'b1);
        check("hold_payload", {out_rd, out_err, out_data}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {out_rd, out_err, out_data}, 71'h7f_dead_dead_dead_dead);
        end else begin
          exp_e = exp_q.pop_front();
          check("result", {out_rd, out_err, out_data}, exp_e);
        end
      end
      prev_vld = out_valid;
      prev_rdy = out_ready;
      prev_out = {out_rd, out_err, out_data};
    end else begin
      prev_vld = 1'b0;
    end
  end

  task automatic do_load(input logic [63:0] a, input logic [2:0] op, input logic [4:0] rd,
                         input int stall, input int rdelay, input logic [63:0] d,
                         input bit rst_mid);
    logic [65:0] r;
    int n;
    bit is_err;
    r = ref_load(a, op, d);
    is_err = (r[65:64] != 2'b00);
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = a;
    in_memop = op;
    in_rd    = rd;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check1("in_ready_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    if (!rst_mid) begin
      if (!is_err && rdelay >= TO) exp_q.push_back({rd, 2'b10, 64'd0});
      else exp_q.push_back({rd, r[65:64], r[63:0]});
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (is_err) begin
      check1("err_no_req", mem_req_valid, 1'b0);
      check1("err_latency", out_valid, 1'b1);
      return;
    end
    repeat (stall) begin
      check1("req_hold", mem_req_valid, 1'b1);
      check("req_addr_hold", 71'(mem_req_addr), 71'({a[63:3], 3'b000}));
      @(negedge clk);
    end
    check1("req_valid", mem_req_valid, 1'b1);
    check("req_addr", 71'(mem_req_addr), 71'({a[63:3], 3'b000}));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check1("req_drop", mem_req_valid, 1'b0);
    if (rst_mid) begin
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("rst_outputs", {out_rd, out_err, out_data}, 71'd0);
      check("rst_ctrl", 71'({in_ready, out_valid, mem_req_valid}), 71'(3'b100));
      check("rst_req_addr", 71'(mem_req_addr), 71'd0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      @(negedge clk);
      check1("stale_no_valid", out_valid, 1'b0);
      check1("stale_in_ready", in_ready, 1'b1);
      return;
    end
    if (rdelay < TO) begin
      repeat (rdelay) @(negedge clk);
      check1("not_early", out_valid, 1'b0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom, $urandom};
      check1("resp_latency", out_valid, 1'b1);
    end else begin
      repeat (TO) @(negedge clk);
      check1("timeout_latency", out_valid, 1'b1);
      repeat (rdelay - TO) @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data  = d;
      @(negedge clk);
      mem_resp_valid = 1'b0;
    end
  endtask

  localparam logic [63:0] D0 = 64'h1122334485667788;

  initial begin
    logic [63:0] a, d;
    logic [2:0] op;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset_outputs", {out_rd, out_err, out_data}, 71'd0);
    check("reset_ctrl", 71'({in_ready, out_valid, mem_req_valid}), 71'(3'b100));

    do_load(64'h80000003, 3'b000, 5'd1, 0, 0, D0, 1'b0);
    do_load(64'h80000003, 3'b100, 5'd2, 0, 0, D0, 1'b0);
    do_load(64'h80000006, 3'b001, 5'd3, 0, 1, D0, 1'b0);
    do_load(64'h80000000, 3'b010, 5'd4, 1, 0, D0, 1'b0);
    do_load(64'h80000000, 3'b110, 5'd5, 0, 2, D0, 1'b0);
    do_load(64'h80000000, 3'b011, 5'd6, 0, 3, D0, 1'b0);
    do_load(64'h80000002, 3'b010, 5'd7, 0, 0, D0, 1'b0);
    do_load(64'h80000000, 3'b111, 5'd8, 0, 0, D0, 1'b0);
    do_load(64'h80000010, 3'b011, 5'd9, 5, 6, D0, 1'b0);
    do_load(64'h80000014, 3'b110, 5'd10, 0, 1, D0, 1'b0);

    bp_mode = 2;
    do_load(64'h80000001, 3'b100, 5'd11, 0, 0, D0, 1'b0);
    repeat (3) @(negedge clk);
    check1("hold_after_3", out_valid, 1'b1);
    bp_mode = 0;
    do_load(64'h80000008, 3'b011, 5'd12, 0, 1, D0, 1'b1);
    do_load(64'h80000004, 3'b010, 5'd13, 0, 0, D0, 1'b0);

    bp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) a = a & ~(64'd7);
      d  = {$urandom, $urandom};
      do_load(a, op, 5'($urandom), $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1),
              d, 1'b0);
    end

    bp_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 71'(exp_q.size()), 71'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
